// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : RV32I data-memory access stage. Accepts a load/store from the
//             execute stage, runs one req/ack transaction on the data bus,
//             builds byte strobes and lane-replicated data for stores, and
//             extracts and extends load data into read_data (ReadData).
//             The pipeline is stalled while an access is pending.
//  Ports    : clk, rst_n                         clock, async active-low reset
//             mem_valid, mem_we, funct3, addr,   request from execute stage
//             wdata
//             stall, done, access_err, read_data status/result to pipeline
//             bus_req, bus_we, bus_addr,         data bus request side
//             bus_wstrb, bus_wdata
//             bus_rdata, bus_ack                 data bus response side
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    input  logic             mem_we,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] read_data,
    output logic             access_err,
    output logic             bus_req,
    output logic             bus_we,
    output logic [WIDTH-1:0] bus_addr,
    output logic [3:0]       bus_wstrb,
    output logic [WIDTH-1:0] bus_wdata,
    input  logic [WIDTH-1:0] bus_rdata,
    input  logic             bus_ack
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_REQ  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;
    localparam logic [1:0] c_S_ERR  = 2'd3;

    // Counter only has to reach TIMEOUT-1; with TIMEOUT=0 it simply wraps.
    localparam int              c_CW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_LAST   = c_CW'(TIMEOUT - 1);
    localparam logic            c_TO_EN  = (TIMEOUT != 0);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_we;
    logic [2:0]       r_funct3;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_read_data;

    logic             w_legal;
    logic             w_aligned;
    logic [3:0]       w_wstrb;
    logic [WIDTH-1:0] w_wdata;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [WIDTH-1:0] w_load;

    // ------------------------------------------------------------------
    // Request qualification, evaluated on the live inputs in IDLE
    // ------------------------------------------------------------------
    always_comb begin
        w_legal = 1'b0;
        if (mem_we) begin
            w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
        end
    end

    // funct3[1:0] encodes the size for every legal load/store encoding.
    always_comb begin
        w_aligned = 1'b1;
        case (funct3[1:0])
            2'b10:   w_aligned = (addr[1:0] == 2'b00);
            2'b01:   w_aligned = (addr[0] == 1'b0);
            default: w_aligned = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Store lane steering from latched request
    // ------------------------------------------------------------------
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction; funct3[2] selects zero extension (LBU/LHU)
    // ------------------------------------------------------------------
    always_comb begin
        w_byte = bus_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_half = bus_rdata[{r_addr[1], 4'b0000} +: 16];
        case (r_funct3)
            3'b000:  w_load = {{(WIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_load = {{(WIDTH-16){w_half[15]}}, w_half};
            3'b100:  w_load = {{(WIDTH-8){1'b0}}, w_byte};
            3'b101:  w_load = {{(WIDTH-16){1'b0}}, w_half};
            default: w_load = bus_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (mem_valid) begin
                    w_state_nxt = (w_legal && w_aligned) ? c_S_REQ : c_S_ERR;
                end
            end
            c_S_REQ: begin
                if (bus_ack) begin
                    w_state_nxt = c_S_DONE;
                end else if (c_TO_EN && (r_cnt == c_LAST)) begin
                    w_state_nxt = c_S_ERR;
                end
            end
            c_S_DONE: w_state_nxt = c_S_IDLE;
            c_S_ERR:  w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Bus signals are forced to zero outside REQ so nothing
    // leaks onto the bus in IDLE/DONE/ERR.
    // ------------------------------------------------------------------
    always_comb begin
        stall      = 1'b0;
        done       = 1'b0;
        access_err = 1'b0;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_wstrb  = 4'b0000;
        bus_wdata  = '0;
        case (r_state)
            c_S_IDLE: stall = mem_valid;
            c_S_REQ: begin
                stall     = 1'b1;
                bus_req   = 1'b1;
                bus_we    = r_we;
                bus_addr  = {r_addr[WIDTH-1:2], 2'b00};
                bus_wstrb = r_we ? w_wstrb : 4'b0000;
                bus_wdata = w_wdata;
            end
            c_S_DONE: done = 1'b1;
            c_S_ERR: begin
                done       = 1'b1;
                access_err = 1'b1;
            end
            default: stall = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_read_data <= '0;
        end else begin
            if ((r_state == c_S_IDLE) && mem_valid) begin
                r_we     <= mem_we;
                r_funct3 <= funct3;
                r_addr   <= addr;
                r_wdata  <= wdata;
            end

            if (r_state == c_S_REQ) begin
                r_cnt <= r_cnt + c_CW'(1);
            end else begin
                r_cnt <= '0;
            end

            // Clearing on entry to ERR makes the zero visible alongside done.
            if ((r_state == c_S_REQ) && bus_ack && !r_we) begin
                r_read_data <= w_load;
            end else if (w_state_nxt == c_S_ERR) begin
                r_read_data <= '0;
            end
        end
    end

    assign read_data = r_read_data;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Self-checking bench for load_store_unit. Directed accesses push
//             expected retirement results and bus beats into queues; monitor
//             processes pop and compare whenever the DUT retires or the bus
//             completes a beat.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    typedef struct {
        logic        err;
        logic [31:0] rd;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wd;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall, done, access_err, bus_req, bus_we;
    logic [31:0] read_data, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;

    // Second instance with the timeout disabled
    logic        z_valid = 1'b0;
    logic [31:0] z_addr = '0;
    logic [31:0] z_rdata = '0;
    logic        z_ack = 1'b0;
    logic        z_stall, z_done, z_err, z_req, z_we;
    logic [31:0] z_read_data, z_baddr, z_bwdata;
    logic [3:0]  z_wstrb;

    int n_vec = 0;
    int n_err = 0;
    resp_t rq[$];
    beat_t bq[$];
    logic [31:0] last_rd = '0;

    load_store_unit #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_we(mem_we),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
        .read_data(read_data), .access_err(access_err), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    load_store_unit #(.WIDTH(32), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_valid(z_valid), .mem_we(1'b0),
        .funct3(3'b010), .addr(z_addr), .wdata(32'h0), .stall(z_stall), .done(z_done),
        .read_data(z_read_data), .access_err(z_err), .bus_req(z_req),
        .bus_we(z_we), .bus_addr(z_baddr), .bus_wstrb(z_wstrb),
        .bus_wdata(z_bwdata), .bus_rdata(z_rdata), .bus_ack(z_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Retirement monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (rq.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'h0);
            end else begin
                resp_t r;
                r = rq.pop_front();
                chk("access_err", 32'(access_err), 32'(r.err));
                chk("read_data", read_data, r.rd);
                chk("stall_at_done", 32'(stall), 32'h0);
            end
        end
    end

    // Bus beat monitor
    always @(negedge clk) begin
        if (rst_n && bus_req && bus_ack) begin
            if (bq.size() == 0) begin
                chk("unexpected_beat", 32'(bus_ack), 32'h0);
            end else begin
                beat_t b;
                b = bq.pop_front();
                chk("bus_addr", bus_addr, b.addr);
                chk("bus_we", 32'(bus_we), 32'(b.we));
                chk("bus_wstrb", 32'(bus_wstrb), 32'(b.strb));
                if (b.we) chk("bus_wdata", bus_wdata, b.wd);
            end
        end
    end

    // One access: ack_dly = REQ cycles before ack (255 = never),
    // nreq = expected number of cycles bus_req is high.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat, input int ack_dly,
                          input logic err, input logic [31:0] exp_rd, input int nreq,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wd);
        int lat;
        int reqc;
        resp_t r;
        beat_t b;
        if (err) last_rd = '0;
        else if (!we) last_rd = exp_rd;
        r.err = err;
        r.rd  = last_rd;
        rq.push_back(r);
        if (!err) begin
            b.addr = {a[31:2], 2'b00};
            b.we   = we;
            b.strb = exp_strb;
            b.wd   = exp_wd;
            bq.push_back(b);
        end
        @(negedge clk);
        mem_valid = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
        #1 chk("stall_accept", 32'(stall), 32'h1);
        @(posedge clk); #1;
        mem_valid = 1'b0;
        lat  = 1;
        reqc = 0;
        while (!done && lat < 40) begin
            bus_ack   = (lat - 1 == ack_dly);
            bus_rdata = rdat;
            if (bus_req) begin
                reqc++;
                chk("stall_req", 32'(stall), 32'h1);
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
            lat++;
        end
        chk("done_seen", 32'(done), 32'h1);
        chk("req_cycles", 32'(reqc), 32'(nreq));
        chk("latency", 32'(lat), 32'(nreq + 1));
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int zc;
        int zreq;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_read_data", read_data, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_wstrb", 32'(bus_wstrb), 32'h0);
        chk("rst_access_err", 32'(access_err), 32'h0);

        //      we    f3      addr        wdata        rdata        dly err exp_rd       nreq strb     wdata
        access(1'b0, 3'b000, 32'h1003, 32'h0,       32'h80FF1234, 0, 0, 32'hFFFFFF80, 1, 4'b0000, 32'h0);
        access(1'b0, 3'b101, 32'h2002, 32'h0,       32'hBEEF0001, 0, 0, 32'h0000BEEF, 1, 4'b0000, 32'h0);
        access(1'b0, 3'b001, 32'h2002, 32'h0,       32'hBEEF0001, 0, 0, 32'hFFFFBEEF, 1, 4'b0000, 32'h0);
        access(1'b1, 3'b000, 32'h0013, 32'h000000AB, 32'h0,       0, 0, 32'h0,        1, 4'b1000, 32'hABABABAB);
        access(1'b1, 3'b000, 32'h0011, 32'h000000AB, 32'h0,       1, 0, 32'h0,        2, 4'b0010, 32'hABABABAB);
        access(1'b1, 3'b001, 32'h0012, 32'h00001234, 32'h0,       0, 0, 32'h0,        1, 4'b1100, 32'h12341234);
        access(1'b1, 3'b010, 32'h0020, 32'hDEADBEEF, 32'h0,       0, 0, 32'h0,        1, 4'b1111, 32'hDEADBEEF);
        access(1'b0, 3'b010, 32'h0006, 32'h0,       32'h0,      255, 1, 32'h0,        0, 4'b0000, 32'h0);
        access(1'b0, 3'b100, 32'h1001, 32'h0,       32'h0000F000, 2, 0, 32'h000000F0, 3, 4'b0000, 32'h0);
        access(1'b1, 3'b011, 32'h0000, 32'h1,       32'h0,      255, 1, 32'h0,        0, 4'b0000, 32'h0);
        access(1'b0, 3'b110, 32'h0000, 32'h0,       32'h0,      255, 1, 32'h0,        0, 4'b0000, 32'h0);
        access(1'b0, 3'b001, 32'h0003, 32'h0,       32'h0,      255, 1, 32'h0,        0, 4'b0000, 32'h0);
        access(1'b0, 3'b010, 32'h0200, 32'h0,       32'hCAFEF00D, 3, 0, 32'hCAFEF00D, 4, 4'b0000, 32'h0);
        access(1'b0, 3'b010, 32'h0100, 32'h0,       32'h12345678, 255, 1, 32'h0,      4, 4'b0000, 32'h0);
        access(1'b0, 3'b010, 32'h0300, 32'h0,       32'h89ABCDEF, 1, 0, 32'h89ABCDEF, 2, 4'b0000, 32'h0);

        // Reset in the middle of REQ
        @(negedge clk);
        mem_valid = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h400;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        @(posedge clk); #1;
        chk("req_before_rst", 32'(bus_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_req", 32'(bus_req), 32'h0);
        chk("rst_async_stall", 32'(stall), 32'h0);
        chk("rst_async_rd", read_data, 32'h0);
        last_rd = '0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(negedge clk); bus_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("late_ack_done", 32'(done), 32'h0);
        chk("late_ack_rd", read_data, 32'h0);
        chk("late_ack_req", 32'(bus_req), 32'h0);

        // No-timeout instance: ack arrives in the 20th REQ cycle
        @(negedge clk);
        z_valid = 1'b1; z_addr = 32'h44;
        @(posedge clk); #1;
        z_valid = 1'b0;
        zc = 0;
        zreq = 0;
        while (!z_done && zc < 40) begin
            z_ack   = (zc == 19);
            z_rdata = 32'h13572468;
            if (z_req) zreq++;
            @(posedge clk); #1;
            z_ack = 1'b0;
            zc++;
        end
        chk("nto_done", 32'(z_done), 32'h1);
        chk("nto_err", 32'(z_err), 32'h0);
        chk("nto_rd", z_read_data, 32'h13572468);
        chk("nto_req_cycles", 32'(zreq), 32'd20);

        repeat (2) @(posedge clk);
        #1;
        chk("resp_queue_empty", 32'(rq.size()), 32'h0);
        chk("beat_queue_empty", 32'(bq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
